// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode constants and
// depth computation.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: registered write port, combinational read port.
// Contents are deliberately not reset.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] q
);

  localparam int unsigned DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign q = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact fill count, almost-full/empty thresholds,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned ASIZE    = 4,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = FIFO_STD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    DEPTH    = fifo_depth(ASIZE);
  localparam logic [ASIZE:0] DepthCnt = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AfLvl    = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AeLvl    = AE_LEVEL[ASIZE:0];

  logic [ASIZE-1:0] wbin_q, wbin_d;
  logic [ASIZE-1:0] rbin_q, rbin_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_ok, rd_ok;
  logic [DSIZE-1:0] ram_q;

  // Flags decode the registered count directly, so they never glitch.
  assign wfull         = (count_q == DepthCnt);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AfLvl);
  assign ralmost_empty = (count_q <= AeLvl);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  always_comb begin
    wbin_d      = wbin_q;
    rbin_d      = rbin_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) wbin_d = wbin_q + 1'b1;
    if (rd_ok) rbin_d = rbin_q + 1'b1;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A fresh error outranks a clear in the same cycle.
    if (winc & wfull)  overflow_d = 1'b1;
    else if (clr_err)  overflow_d = 1'b0;
    if (rinc & rempty) underflow_d = 1'b1;
    else if (clr_err)  underflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q      <= '0;
      rbin_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      rbin_q      <= rbin_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wbin_q),
    .wdata(wdata),
    .raddr(rbin_q),
    .q    (ram_q)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rdata = ram_q;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (rd_ok) begin
        rdata_q <= ram_q;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share stimulus and are
// compared every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] s_rdata, f_rdata;
  logic       s_wfull, s_rempty, s_af, s_ae, s_ovf, s_unf;
  logic       f_wfull, f_rempty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_count, f_count;

  sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
    .rdata(s_rdata), .wfull(s_wfull), .rempty(s_rempty), .walmost_full(s_af),
    .ralmost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .walmost_full(f_af),
    .ralmost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the sticky flags.
  logic [7:0] mq[$];
  logic [7:0] m_rdata = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  initial begin
    bit full, empty;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_rdata = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
      end else begin
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (rinc && !empty) m_rdata = mq.pop_front();
        if (winc && !full) mq.push_back(wdata);
        if (winc && full) m_ovf = 1'b1;
        else if (clr_err) m_ovf = 1'b0;
        if (rinc && empty) m_unf = 1'b1;
        else if (clr_err) m_unf = 1'b0;
      end
    end
  end

  initial begin
    int n;
    forever begin
      @(negedge clk);
      n = mq.size();
      chk("s_count", 32'(s_count), 32'(n));
      chk("f_count", 32'(f_count), 32'(n));
      chk("s_wfull", 32'(s_wfull), 32'(n == DEPTH));
      chk("f_wfull", 32'(f_wfull), 32'(n == DEPTH));
      chk("s_rempty", 32'(s_rempty), 32'(n == 0));
      chk("f_rempty", 32'(f_rempty), 32'(n == 0));
      chk("s_afull", 32'(s_af), 32'(n >= AF));
      chk("f_afull", 32'(f_af), 32'(n >= AF));
      chk("s_aempty", 32'(s_ae), 32'(n <= AE));
      chk("f_aempty", 32'(f_ae), 32'(n <= AE));
      chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
      chk("s_unf", 32'(s_unf), 32'(m_unf));
      chk("f_unf", 32'(f_unf), 32'(m_unf));
      chk("s_rdata", 32'(s_rdata), 32'(m_rdata));
      if (n > 0) chk("f_rdata", 32'(f_rdata), 32'(mq[0]));
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    winc    = w;
    rinc    = r;
    wdata   = d;
    clr_err = c;
    @(posedge clk);
    #1;
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    int wp, rp;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_count", 32'(s_count), 0);
    chk("rst_rempty", 32'(s_rempty), 1);
    chk("rst_aempty", 32'(s_ae), 1);
    chk("rst_wfull", 32'(s_wfull), 0);
    chk("rst_afull", 32'(s_af), 0);
    chk("rst_rdata", 32'(s_rdata), 0);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0);
      chk("fill_count", 32'(s_count), 32'(i));
      if (i == 13) chk("afull_13", 32'(s_af), 0);
      if (i == 14) chk("afull_14", 32'(s_af), 1);
    end
    chk("full_wfull", 32'(s_wfull), 1);
    chk("full_ovf", 32'(s_ovf), 0);

    // Drain in order; standard read data is valid right after the accepting edge.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_rdata", 32'(s_rdata), 32'(i));
      if (i == 13) chk("aempty_3", 32'(s_ae), 0);
      if (i == 14) chk("aempty_2", 32'(s_ae), 1);
    end
    chk("drain_rempty", 32'(s_rempty), 1);

    // FWFT: word visible in the same cycle as its write.
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("fwft_rdata", 32'(f_rdata), 32'h A5);
    chk("fwft_rempty", 32'(f_rempty), 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_pop_rempty", 32'(f_rempty), 1);
    chk("fwft_pop_count", 32'(f_count), 0);

    // Full with simultaneous write/read: read wins, write dropped.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'($urandom_range(0, 8'h76)), 1'b0);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    chk("fullrw_count", 32'(s_count), 15);
    chk("fullrw_ovf", 32'(s_ovf), 1);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("no_77", 32'(s_rdata == 8'h77), 0);
    end
    // Empty with simultaneous write/read: write wins, read flagged.
    cyc(1'b1, 1'b1, 8'h3C, 1'b0);
    chk("emptyrw_count", 32'(s_count), 1);
    chk("emptyrw_unf", 32'(s_unf), 1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("emptyrw_rdata", 32'(s_rdata), 32'h3C);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf", 32'(s_ovf), 0);
    chk("clr_unf", 32'(s_unf), 0);

    // Pointer wrap: 40 write/read pairs.
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
      chk("wrap_count1", 32'(s_count), 1);
      chk("wrap_fwft", 32'(f_rdata), 32'(8'h40 + i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      chk("wrap_rdata", 32'(s_rdata), 32'(8'h40 + i));
      chk("wrap_count0", 32'(s_count), 0);
    end

    // Sticky overflow versus clr_err.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    chk("ovf_set", 32'(s_ovf), 1);
    cyc(1'b1, 1'b0, 8'h22, 1'b1);
    chk("ovf_clr_collide", 32'(s_ovf), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(s_ovf), 0);

    // Random traffic with shifting bias.
    for (int ph = 0; ph < 6; ph++) begin
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 400; i++) begin
        cyc(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp), 8'($urandom),
            1'($urandom_range(0, 15) == 0));
      end
    end

    // Async reset with 5 words stored.
    for (int i = 0; i < 40 && s_rempty !== 1'b1; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("pre_rst_empty", 32'(s_rempty), 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    chk("pre_rst_count", 32'(s_count), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(s_count), 0);
    chk("arst_rempty", 32'(s_rempty), 1);
    chk("arst_f_rempty", 32'(f_rempty), 1);
    chk("arst_rdata", 32'(s_rdata), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("post_rst_count", 32'(s_count), 1);
    chk("post_rst_fwft", 32'(f_rdata), 32'h5A);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_rdata", 32'(s_rdata), 32'h5A);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
